serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder. It shifts two operands LSB-first through one full_adder cell.
//   A carry flip-flop links consecutive bit slices.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_if.sv | 30 +++
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtract mode is selected with the SERIAL_SUB_EN macro.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width for the default 8-bit configuration.
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Counter width for an arbitrary operand width (never below 1 bit).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between upstream control (master) and the serial adder (slave).
// The sub signal exists only when SERIAL_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  import serial_adder_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_SUB_EN
  modport master (output start, a_in, b_in, cin_in, sub,
                  input  busy, done, sum, cout);
  modport slave  (input  start, a_in, b_in, cin_in, sub,
                  output busy, done, sum, cout);
`else
  modport master (output start, a_in, b_in, cin_in,
                  input  busy, done, sum, cout);
  modport slave  (input  start, a_in, b_in, cin_in,
                  output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used as the bit slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full_adder,
// a carry flip-flop links consecutive bit slices.
// Define SERIAL_SUB_EN to add the sub input (a - b via ~b and carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int BIT_CNT_W = cnt_width(WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

  state_t                 state_q;
  logic [WIDTH-1:0]       a_sr_q, b_sr_q, res_sr_q;
  logic [WIDTH-1:0]       a_sr_d, b_sr_d, res_sr_d;
  logic                   carry_q, carry_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic                   busy_q, done_q;
  logic [WIDTH-1:0]       b_load;
  logic                   cin_load;
  logic                   fa_s, fa_cout;

  // The one bit-slice cell: current LSBs plus the linking carry.
  full_adder u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Operand B and carry-in as captured on an accepted start (inverted B for subtract).
  always_comb begin
    b_load   = bus.b_in;
    cin_load = bus.cin_in;
`ifdef SERIAL_SUB_EN
    if (bus.sub) begin
      b_load   = ~bus.b_in;
      cin_load = 1'b1;
    end
`endif
  end

  // Next values for one shift step: new sum bit enters at the MSB.
  always_comb begin
    a_sr_d   = a_sr_q >> 1;
    b_sr_d   = b_sr_q >> 1;
    res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
    carry_d  = fa_cout;
  end

  // Control FSM with datapath registers and registered busy/done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      res_sr_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q   <= SHIFT;
            a_sr_q    <= bus.a_in;
            b_sr_q    <= b_load;
            carry_q   <= cin_load;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr_q    <= a_sr_d;
          b_sr_q    <= b_sr_d;
          res_sr_q  <= res_sr_d;
          carry_q   <= carry_d;
          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // Start is ignored here; the result stays on sum/cout while idle.
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = res_sr_q;
  assign bus.cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back checks for serial_adder at WIDTH=8.
// Build with SERIAL_SUB_EN defined to also exercise subtract mode.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
`ifdef SERIAL_SUB_EN
  logic sub_v = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Issue one request and wait (bounded) for its done pulse; no checking here.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic co,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.cin_in = cin;
`ifdef SERIAL_SUB_EN
    bus.sub    = sub_v;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    s  = bus.sum;
    co = bus.cout;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.cin_in = 1'b0;
`ifdef SERIAL_SUB_EN
    bus.sub    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum: got %h expected 00", bus.sum); end
    vectors++; if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
    $display("reset: busy=%b done=%b sum=%h cout=%b", bus.busy, bus.done, bus.sum, bus.cout);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [7:0] va [4] = '{8'h0F, 8'hFF, 8'hFF, 8'hA5};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'hFF, 8'h5A};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [4] = '{8'h10, 8'h00, 8'hFF, 8'h00};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] s;
    logic       co, bok;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], s, co, lat, bok);
      $display("add %h+%h+%b: sum=%h cout=%b lat=%0d", va[i], vb[i], vc[i], s, co, lat);
      vectors++; if (lat !== W + 1) begin miscompares++; $display("FAIL add_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL add_busy[%0d]: got low during op expected high", i); end
      vectors++; if (s !== es[i]) begin miscompares++; $display("FAIL add_sum[%0d]: got %h expected %h", i, s, es[i]); end
      vectors++; if (co !== ec[i]) begin miscompares++; $display("FAIL add_cout[%0d]: got %b expected %b", i, co, ec[i]); end
      @(negedge clk);
      vectors++; if ({bus.busy, bus.done} !== 2'b00) begin miscompares++; $display("FAIL add_idle[%0d]: got busy/done %b expected 00", i, {bus.busy, bus.done}); end
      vectors++; if (bus.sum !== es[i]) begin miscompares++; $display("FAIL add_hold[%0d]: got %h expected %h", i, bus.sum, es[i]); end
    end
  endtask

  task automatic test_busy_ignore();
    int         ndone = 0;
    logic [7:0] s = 8'hXX;
    logic       co = 1'bx;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 8'h12; bus.b_in = 8'h34; bus.cin_in = 1'b0;
    @(negedge clk);          // after accept edge E0
    bus.start = 1'b0;
    @(negedge clk);          // after E1
    @(negedge clk);          // after E2
    bus.start = 1'b1; bus.a_in = 8'hAA; bus.b_in = 8'h55;
    @(negedge clk);          // after E3
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin ndone++; s = bus.sum; co = bus.cout; end
    end
    $display("busy_ignore: dones=%0d sum=%h cout=%b", ndone, s, co);
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    vectors++; if (s !== 8'h46) begin miscompares++; $display("FAIL ignore_sum: got %h expected 46", s); end
    vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL ignore_cout: got %b expected 0", co); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    int         ndone = 0;
    logic [7:0] s;
    logic       co, bok;
    int         lat;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 8'hFF; bus.b_in = 8'hFF; bus.cin_in = 1'b1;
    @(negedge clk);          // after E0
    bus.start = 1'b0;
    repeat (3) @(negedge clk); // after E3: fourth SHIFT cycle
    rst_n = 1'b0;
    @(negedge clk);
    $display("abort: busy=%b done=%b sum=%h cout=%b", bus.busy, bus.done, bus.sum, bus.cout);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    vectors++; if (bus.sum !== 8'h00) begin miscompares++; $display("FAIL abort_sum: got %h expected 00", bus.sum); end
    vectors++; if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL abort_cout: got %b expected 0", bus.cout); end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", ndone); end
    run_op(8'h80, 8'h80, 1'b0, s, co, lat, bok);
    $display("after abort 80+80+0: sum=%h cout=%b lat=%0d", s, co, lat);
    vectors++; if (s !== 8'h00) begin miscompares++; $display("FAIL abort_next_sum: got %h expected 00", s); end
    vectors++; if (co !== 1'b1) begin miscompares++; $display("FAIL abort_next_cout: got %b expected 1", co); end
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    logic [7:0] s;
    logic       co, bok;
    int         lat;
    sub_v = 1'b1;
    run_op(8'h05, 8'h03, 1'b0, s, co, lat, bok);
    $display("sub 05-03: sum=%h cout=%b", s, co);
    vectors++; if (s !== 8'h02) begin miscompares++; $display("FAIL sub1_sum: got %h expected 02", s); end
    vectors++; if (co !== 1'b1) begin miscompares++; $display("FAIL sub1_cout: got %b expected 1", co); end
    run_op(8'h03, 8'h05, 1'b1, s, co, lat, bok);
    $display("sub 03-05: sum=%h cout=%b", s, co);
    vectors++; if (s !== 8'hFE) begin miscompares++; $display("FAIL sub2_sum: got %h expected FE", s); end
    vectors++; if (co !== 1'b0) begin miscompares++; $display("FAIL sub2_cout: got %b expected 0", co); end
    sub_v = 1'b0;
    bus.sub = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [8:0] exp_v;
    int         n;
    @(negedge clk);
    bus.a_in = 8'($urandom); bus.b_in = 8'($urandom); bus.cin_in = 1'($urandom);
    exp_v = 9'(bus.a_in) + 9'(bus.b_in) + 9'(bus.cin_in);
    bus.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.done && n < 40);
      vectors++;
      if (!bus.done) begin
        miscompares++;
        $display("FAIL b2b_timeout[%0d]: got no done in %0d cycles expected done", i, n);
        break;
      end
      if ({bus.cout, bus.sum} !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_result[%0d]: got %h expected %h", i, {bus.cout, bus.sum}, exp_v);
      end else begin
        $display("b2b[%0d]: {cout,sum}=%h", i, {bus.cout, bus.sum});
      end
      if (i < 199) begin
        bus.a_in = 8'($urandom); bus.b_in = 8'($urandom); bus.cin_in = 1'($urandom);
        exp_v = 9'(bus.a_in) + 9'(bus.b_in) + 9'(bus.cin_in);
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_busy_ignore();
    test_reset_abort();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
